// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: decodes 16-bit command packets from an SPI slave,
// services calibration register reads/writes and resolver angle requests,
// and hands a 16-bit response word back to the slave.
module spi_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter logic [11:0] OFFSET_RST  = 12'h000,
  parameter logic [11:0] GAIN_RST    = 12'h800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rdy,
  input  logic [15:0] cmd_rcvd,
  input  logic        rsp_rdy,
  output logic        wrt,
  output logic [15:0] tx_data,
  output logic        angle_req,
  input  logic        angle_vld,
  input  logic [11:0] angle,
  output logic [11:0] cal_offset,
  output logic [11:0] cal_gain,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam int unsigned      CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]    TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT_ANG,
    RESP,
    WAIT_RSP
  } state_e;

  state_e          state_q, state_d;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            armed_q, armed_d;
  logic            pend_q, pend_d;
  logic [15:0]     pend_cmd_q, pend_cmd_d;
  logic [15:0]     cmd_q, cmd_d;
  logic [15:0]     rsp_q, rsp_d;
  logic [15:0]     tx_data_q, tx_data_d;
  logic            wrt_q, wrt_d;
  logic            angle_req_q, angle_req_d;
  logic [11:0]     cal_offset_q, cal_offset_d;
  logic [11:0]     cal_gain_q, cal_gain_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            err_inc;
  logic            cmd_rise;

  // armed_q only sets once cmd_rdy has been seen low after reset, so a level
  // held high across reset release never looks like a fresh command.
  assign cmd_rise = cmd_rdy & ~cmd_rdy_q & armed_q;

  assign wrt        = wrt_q;
  assign tx_data    = tx_data_q;
  assign angle_req  = angle_req_q;
  assign cal_offset = cal_offset_q;
  assign cal_gain   = cal_gain_q;
  assign err_cnt    = err_cnt_q;
  assign busy       = (state_q != IDLE);

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_rdy_q    <= 1'b0;
      armed_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_cmd_q   <= '0;
      cmd_q        <= '0;
      rsp_q        <= '0;
      tx_data_q    <= '0;
      wrt_q        <= 1'b0;
      angle_req_q  <= 1'b0;
      cal_offset_q <= OFFSET_RST;
      cal_gain_q   <= GAIN_RST;
      err_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cmd_rdy_q    <= cmd_rdy_d;
      armed_q      <= armed_d;
      pend_q       <= pend_d;
      pend_cmd_q   <= pend_cmd_d;
      cmd_q        <= cmd_d;
      rsp_q        <= rsp_d;
      tx_data_q    <= tx_data_d;
      wrt_q        <= wrt_d;
      angle_req_q  <= angle_req_d;
      cal_offset_q <= cal_offset_d;
      cal_gain_q   <= cal_gain_d;
      err_cnt_q    <= err_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  // Next-state, command decode, pending-command capture and error counting.
  always_comb begin
    state_d      = state_q;
    cmd_rdy_d    = cmd_rdy;
    armed_d      = armed_q | ~cmd_rdy;
    pend_d       = pend_q;
    pend_cmd_d   = pend_cmd_q;
    cmd_d        = cmd_q;
    rsp_d        = rsp_q;
    tx_data_d    = tx_data_q;
    wrt_d        = 1'b0;
    angle_req_d  = angle_req_q;
    cal_offset_d = cal_offset_q;
    cal_gain_d   = cal_gain_q;
    err_cnt_d    = err_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    err_inc      = 1'b0;

    // A new command while busy is parked; overwriting an unserved one is an error.
    if (cmd_rise && (state_q != IDLE)) begin
      if (pend_q) err_inc = 1'b1;
      pend_d     = 1'b1;
      pend_cmd_d = cmd_rcvd;
    end

    case (state_q)
      IDLE: begin
        if (cmd_rise) begin
          if (pend_q) err_inc = 1'b1;
          cmd_d   = cmd_rcvd;
          pend_d  = 1'b0;
          state_d = DECODE;
        end else if (pend_q) begin
          cmd_d   = pend_cmd_q;
          pend_d  = 1'b0;
          state_d = DECODE;
        end
      end

      DECODE: begin
        state_d = RESP;
        case (cmd_q[15:12])
          4'h0: rsp_d = '0;
          4'h1: begin
            angle_req_d = 1'b1;
            tmo_cnt_d   = '0;
            state_d     = WAIT_ANG;
          end
          4'h2: begin
            cal_offset_d = cmd_q[11:0];
            rsp_d        = {4'h2, cmd_q[11:0]};
          end
          4'h3: begin
            cal_gain_d = cmd_q[11:0];
            rsp_d      = {4'h3, cmd_q[11:0]};
          end
          4'h4: rsp_d = {4'h4, cal_offset_q};
          4'h5: rsp_d = {4'h5, cal_gain_q};
          default: begin
            rsp_d   = '1;
            err_inc = 1'b1;
          end
        endcase
      end

      WAIT_ANG: begin
        // angle_vld is checked first so it wins a tie with the timeout.
        if (angle_vld) begin
          rsp_d       = {4'h1, angle};
          angle_req_d = 1'b0;
          state_d     = RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          rsp_d       = 16'hE000;
          err_inc     = 1'b1;
          angle_req_d = 1'b0;
          state_d     = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
      end

      RESP: begin
        tx_data_d = rsp_q;
        wrt_d     = 1'b1;
        state_d   = WAIT_RSP;
      end

      WAIT_RSP: begin
        if (rsp_rdy) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

endmodule
